memory_port_arbiter: RTL and testbench

- Shares one single-port word memory between two requesters: the instruction-fetch port (read-only) and the data port (load/store).
- Arbitrates between them, registers the winning request, and drives the memory strobes for exactly one cycle.
- Waits out the registered read latency, then returns data with a one-cycle ack.
- Sits between the CPU core and the memory block; one transaction is outstanding at a time.

---
 rtl/memory_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_memory_port_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Two-way arbiter sharing one single-port word memory between fetch and data.
// One transaction in flight; fetch is forced through after a data streak.
module memory_port_arbiter #(
  parameter int READ_LATENCY    = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wren,
  output logic        mem_rren,
  output logic        mem_en,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_e;

  localparam logic [3:0] MAXS = 4'(MAX_DATA_STREAK);
  localparam logic [2:0] RLAT = 3'(READ_LATENCY);

  state_e      state_q, state_d;
  logic        own_q, own_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  streak_q, streak_d;
  logic [2:0]  lat_q, lat_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        pick_d;

  always_comb begin
    state_d    = state_q;
    own_d      = own_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    streak_d   = streak_q;
    lat_d      = lat_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    pick_d     = 1'b0;
    mem_en     = 1'b0;
    mem_wren   = 1'b0;
    mem_rren   = 1'b0;
    if_ack     = 1'b0;
    d_ack      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          pick_d  = d_req && (!if_req || streak_q != MAXS);
          own_d   = pick_d;
          we_d    = pick_d && d_we;
          addr_d  = pick_d ? d_addr : if_addr;
          wdata_d = pick_d ? d_wdata : '0;
          // Streak only grows while fetch is actually being held off
          if (pick_d && if_req)
            streak_d = (streak_q == MAXS) ? streak_q
                                          : streak_q + 4'd1;
          else
            streak_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en   = 1'b1;
        mem_wren = we_q;
        mem_rren = !we_q;
        if (we_q) begin
          state_d = S_ACK;
        end else begin
          lat_d   = RLAT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          if (own_q) d_rdata_d = mem_rdata;
          else       if_rdata_d = mem_rdata;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if_ack  = !own_q;
        d_ack   = own_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A reset cycle must never let a strobe or ack escape
    if (rst) begin
      mem_en   = 1'b0;
      mem_wren = 1'b0;
      mem_rren = 1'b0;
      if_ack   = 1'b0;
      d_ack    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      own_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      streak_q   <= '0;
      lat_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      streak_q   <= streak_d;
      lat_q      <= lat_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: memory stand-in, scoreboard memory and
// a streak-rule model drive randomized and directed transactions.
module tb_memory_port_arbiter;

  localparam int RL   = 3;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [29:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [29:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wren;
  logic        mem_rren;
  logic        mem_en;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  always #5 clk = ~clk;

  memory_port_arbiter #(
    .READ_LATENCY   (RL),
    .MAX_DATA_STREAK(MAXS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wren (mem_wren),
    .mem_rren (mem_rren),
    .mem_en   (mem_en),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic logic [31:0] pre(input int i);
    case (i)
      0:       return 32'h20082000;
      2049:    return 32'h00000022;
      2112:    return 32'h00000011;
      default: return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endcase
  endfunction

  // Memory block stand-in: registered read, garbage outside the valid cycle
  logic [31:0] mem [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        loaded = 1'b0;
  int          pend_k = 0;
  logic [31:0] pend_dat = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pre(i);
      loaded <= 1'b1;
    end
    if (mem_en && mem_wren) mem[mem_addr[11:0]] <= mem_wdata;
    if (mem_en && mem_rren) begin
      pend_k    <= RL;
      pend_dat  <= mem[mem_addr[11:0]];
      mem_rdata <= (RL == 1) ? mem[mem_addr[11:0]] : $urandom;
    end else begin
      if (pend_k > 0) pend_k <= pend_k - 1;
      mem_rdata <= (pend_k == 2) ? pend_dat : $urandom;
    end
  end

  int          n_issue = 0;
  int          n_ifack = 0;
  int          n_dack  = 0;
  int          last_issue = -1;
  logic        last_we = 1'b0;
  logic        last_rren = 1'b0;
  logic [29:0] last_addr = '0;
  logic [31:0] last_wdata = '0;

  always @(negedge clk) begin
    if (mem_en) begin
      n_issue    <= n_issue + 1;
      last_issue <= cyc;
      last_we    <= mem_wren;
      last_rren  <= mem_rren;
      last_addr  <= mem_addr;
      last_wdata <= mem_wdata;
    end
    if (if_ack) n_ifack <= n_ifack + 1;
    if (d_ack)  n_dack  <= n_dack + 1;
  end

  int          streak_m = 0;
  logic [31:0] exp_if = '0;
  logic [31:0] exp_d  = '0;

  function automatic int sat_inc(input int s);
    return (s < MAXS) ? s + 1 : MAXS;
  endfunction

  task automatic run_pair(input bit fr, input bit dr, input bit we,
                          input logic [29:0] fa, input logic [29:0] da,
                          input logic [31:0] wd, output int t0o);
    bit fdone, ddone, first, exp_dfirst, is_d;
    int t0, lat;
    @(posedge clk); #1;
    if_req = fr; if_addr = fa;
    d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
    t0 = cyc; t0o = t0;
    fdone = !fr; ddone = !dr; first = 1'b1;
    exp_dfirst = dr && (!fr || streak_m != MAXS);
    for (int k = 0; k < 40 && !(fdone && ddone); k++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        is_d = d_ack;
        total++;
        if ((if_ack && d_ack) || (is_d ? ddone : fdone)) begin
          bad++;
          $display("FAIL pair_ack: if_ack=%b d_ack=%b unexpected", if_ack, d_ack);
        end
        if (first) begin
          total++;
          if (is_d !== exp_dfirst) begin
            bad++;
            $display("FAIL first_winner: got data=%b want data=%b", is_d, exp_dfirst);
          end
        end
        lat = (is_d && we) ? 2 : 2 + RL;
        total++;
        if (cyc !== t0 + lat) begin
          bad++;
          $display("FAIL pair_latency: got %0d want %0d", cyc - t0, lat);
        end
        if (is_d) begin
          if (we) ref_mem[da[11:0]] = wd;
          else    exp_d = ref_mem[da[11:0]];
          streak_m = (first && fr) ? sat_inc(streak_m) : 0;
          ddone = 1'b1;
        end else begin
          exp_if = ref_mem[fa[11:0]];
          streak_m = 0;
          fdone = 1'b1;
        end
        total++;
        if (if_rdata !== exp_if || d_rdata !== exp_d) begin
          bad++;
          $display("FAIL pair_rdata: got if=%h d=%h want if=%h d=%h",
                   if_rdata, d_rdata, exp_if, exp_d);
        end
        first = 1'b0;
        @(posedge clk); #1;
        t0 = cyc;
        if (fdone) if_req = 1'b0;
        if (ddone) d_req = 1'b0;
      end
    end
    if (!(fdone && ddone)) begin
      total++; bad++;
      $display("FAIL pair_timeout: got fdone=%b ddone=%b want 1 1", fdone, ddone);
      if_req = 1'b0; d_req = 1'b0;
    end
  endtask

  // Requests held continuously; a new address follows each ack
  task automatic run_stream(input int n, input bit use_d);
    int t0, got, ni0, na0;
    bit is_d, exp_dwin;
    logic [29:0] fa, da;
    fa = 30'($urandom_range(0, 4095));
    da = 30'($urandom_range(0, 4095));
    ni0 = n_issue; na0 = n_ifack + n_dack;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = fa;
    d_req = use_d; d_we = 1'b0; d_addr = da;
    t0 = cyc; got = 0;
    for (int k = 0; k < n * 20 && got < n; k++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        is_d = d_ack;
        exp_dwin = use_d && (streak_m != MAXS);
        total++;
        if ((if_ack && d_ack) || is_d !== exp_dwin) begin
          bad++;
          $display("FAIL grant_order[%0d]: got data=%b want data=%b", got, is_d, exp_dwin);
        end
        total++;
        if (cyc !== t0 + 2 + RL) begin
          bad++;
          $display("FAIL stream_spacing[%0d]: got %0d want %0d", got, cyc - t0, 2 + RL);
        end
        if (is_d) begin
          exp_d = ref_mem[da[11:0]];
          streak_m = sat_inc(streak_m);
        end else begin
          exp_if = ref_mem[fa[11:0]];
          streak_m = 0;
        end
        total++;
        if (if_rdata !== exp_if || d_rdata !== exp_d) begin
          bad++;
          $display("FAIL stream_rdata[%0d]: got if=%h d=%h want if=%h d=%h",
                   got, if_rdata, d_rdata, exp_if, exp_d);
        end
        got++;
        @(posedge clk); #1;
        t0 = cyc;
        if (is_d) begin da = 30'($urandom_range(0, 4095)); d_addr = da; end
        else      begin fa = 30'($urandom_range(0, 4095)); if_addr = fa; end
        if (got == n) begin if_req = 1'b0; d_req = 1'b0; end
      end
    end
    if (got < n) begin
      total++; bad++;
      $display("FAIL stream_timeout: got %0d acks want %0d", got, n);
      if_req = 1'b0; d_req = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (n_issue - ni0 !== n || n_ifack + n_dack - na0 !== n) begin
      bad++;
      $display("FAIL stream_count: got issues=%0d acks=%0d want %0d",
               n_issue - ni0, n_ifack + n_dack - na0, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({if_ack, d_ack, mem_en, mem_wren, mem_rren, busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 000000",
               {if_ack, d_ack, mem_en, mem_wren, mem_rren, busy});
    end
    total++;
    if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata: got %h %h want 0 0", if_rdata, d_rdata);
    end
    total++;
    if (mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_mem: got %h %h want 0 0", mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    streak_m = 0; exp_if = '0; exp_d = '0;
  endtask

  task automatic test_fetch_alone();
    int t0, nd, ni;
    nd = n_dack; ni = n_issue;
    run_pair(1'b1, 1'b0, 1'b0, 30'd0, 30'd0, 32'h0, t0);
    total++;
    if (last_issue !== t0 + 1 || last_rren !== 1'b1 || last_we !== 1'b0) begin
      bad++;
      $display("FAIL fetch_issue: got cyc=%0d rren=%b we=%b want cyc=%0d 1 0",
               last_issue - t0, last_rren, last_we, 1);
    end
    total++;
    if (n_dack !== nd || n_issue - ni !== 1) begin
      bad++;
      $display("FAIL fetch_side: got dacks=%0d issues=%0d want 0 1", n_dack - nd, n_issue - ni);
    end
    total++;
    if (if_rdata !== 32'h20082000) begin
      bad++;
      $display("FAIL fetch_word0: got %h want 20082000", if_rdata);
    end
  endtask

  task automatic test_store_load();
    int t0, ni;
    ni = n_issue;
    run_pair(1'b0, 1'b1, 1'b1, 30'd0, 30'd2048, 32'hDEADBEEF, t0);
    total++;
    if (last_we !== 1'b1 || last_rren !== 1'b0 || last_issue !== t0 + 1
        || n_issue - ni !== 1) begin
      bad++;
      $display("FAIL store_strobe: got we=%b rren=%b cyc=%0d n=%0d want 1 0 1 1",
               last_we, last_rren, last_issue - t0, n_issue - ni);
    end
    total++;
    if (last_addr !== 30'd2048 || last_wdata !== 32'hDEADBEEF
        || mem[2048] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL store_data: got a=%0d wd=%h m=%h want 2048 deadbeef",
               last_addr, last_wdata, mem[2048]);
    end
    total++;
    if (d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL store_keeps_rdata: got %h want 0", d_rdata);
    end
    run_pair(1'b0, 1'b1, 1'b0, 30'd0, 30'd2048, 32'h0, t0);
    total++;
    if (d_rdata !== 32'hDEADBEEF || if_rdata !== 32'h20082000) begin
      bad++;
      $display("FAIL load_back: got d=%h if=%h want deadbeef 20082000", d_rdata, if_rdata);
    end
  endtask

  task automatic test_latency();
    int t0;
    run_pair(1'b0, 1'b1, 1'b0, 30'd0, 30'd2112, 32'h0, t0);
    total++;
    if (d_rdata !== 32'h11) begin
      bad++;
      $display("FAIL latency_capture: got %h want 00000011", d_rdata);
    end
  endtask

  task automatic test_drop_req();
    int t0, ack_at;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 30'd2112; t0 = cyc;
    @(posedge clk); #1;
    if_req = 1'b0;
    ack_at = -1;
    for (int k = 0; k < 20 && ack_at < 0; k++) begin
      @(negedge clk);
      if (if_ack) ack_at = cyc;
    end
    total++;
    if (ack_at !== t0 + 2 + RL || if_rdata !== 32'h11) begin
      bad++;
      $display("FAIL drop_req: got ack=%0d rd=%h want ack=%0d rd=00000011",
               ack_at - t0, if_rdata, 2 + RL);
    end
    exp_if = 32'h11; streak_m = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    run_stream(12, 1'b1);
  endtask

  task automatic test_reset_issue();
    int nd;
    nd = n_dack;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 30'd2049; d_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mem_wren !== 1'b0 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL rst_issue_strobe: got en=%b wren=%b want 0 0", mem_en, mem_wren);
    end
    @(posedge clk); #1;
    rst = 1'b0; d_req = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      bad++;
      $display("FAIL rst_issue_state: got busy=%b if=%h d=%h want 0 0 0",
               busy, if_rdata, d_rdata);
    end
    repeat (3) @(negedge clk);
    total++;
    if (mem[2049] !== 32'h22 || n_dack !== nd) begin
      bad++;
      $display("FAIL rst_issue_mem: got m=%h acks=%0d want 00000022 0", mem[2049], n_dack - nd);
    end
    streak_m = 0; exp_if = '0; exp_d = '0;
  endtask

  task automatic test_streak_after_reset();
    run_stream(5, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_stream(6, 1'b0);
  endtask

  task automatic test_random(input int n);
    int t0;
    int sel;
    for (int i = 0; i < n; i++) begin
      sel = int'($urandom_range(1, 3));
      run_pair(sel[0], sel[1], 1'($urandom_range(0, 1)),
               30'($urandom), 30'($urandom), $urandom, t0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = pre(i);
    test_reset();
    test_fetch_alone();
    test_store_load();
    test_latency();
    test_drop_req();
    test_contention();
    test_reset_issue();
    test_streak_after_reset();
    test_back_to_back();
    test_random(30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
